// File: rtl/simd_rs_pkg.sv
// Shared types and constants for the SIMD reservation station.
package simd_rs_pkg;

  localparam int XLEN        = 64;
  localparam int RS_DEPTH    = 8;
  localparam int IDX_LEN     = $clog2(RS_DEPTH);
  localparam int EU_CTL_LEN  = 4;
  localparam int EXCEPT_LEN  = 2;
  localparam int ROB_IDX_LEN = 6;

  // Lifecycle of one reservation-station slot. EMPTY must encode as zero so
  // that a zeroed entry is a free entry.
  typedef enum logic [2:0] {
    RS_EMPTY     = 3'd0,
    RS_PENDING   = 3'd1,
    RS_READY     = 3'd2,
    RS_EXECUTING = 3'd3,
    RS_COMPLETED = 3'd4
  } rs_state_t;

  typedef struct packed {
    rs_state_t               state;
    logic [EU_CTL_LEN-1:0]   ctl;
    logic                    rs1_ready;
    logic [ROB_IDX_LEN-1:0]  rs1_idx;
    logic [XLEN-1:0]         rs1_value;
    logic                    rs2_ready;
    logic [ROB_IDX_LEN-1:0]  rs2_idx;
    logic [XLEN-1:0]         rs2_value;
    logic [ROB_IDX_LEN-1:0]  dest_idx;
    logic [XLEN-1:0]         result;
    logic                    except_raised;
    logic [EXCEPT_LEN-1:0]   except_code;
  } simd_rs_entry_t;

  // True when a still-missing operand is produced by the current CDB broadcast.
  function automatic logic cdb_hit(input logic                   op_ready,
                                   input logic [ROB_IDX_LEN-1:0] op_tag,
                                   input logic                   cdb_valid,
                                   input logic [ROB_IDX_LEN-1:0] cdb_idx);
    return !op_ready && cdb_valid && (op_tag == cdb_idx);
  endfunction

endpackage

// File: rtl/simd_rs_if.sv
// Issue, EU, CDB and flush signals of the SIMD reservation station.
// Names carry the _i/_o direction as seen from the reservation station.
interface simd_rs_if;
  import simd_rs_pkg::*;

  logic                    flush_i;

  logic                    issue_valid_i;
  logic                    issue_ready_o;
  logic [EU_CTL_LEN-1:0]   issue_eu_ctl_i;
  logic                    issue_rs1_ready_i;
  logic [ROB_IDX_LEN-1:0]  issue_rs1_idx_i;
  logic [XLEN-1:0]         issue_rs1_value_i;
  logic                    issue_rs2_ready_i;
  logic [ROB_IDX_LEN-1:0]  issue_rs2_idx_i;
  logic [XLEN-1:0]         issue_rs2_value_i;
  logic [ROB_IDX_LEN-1:0]  issue_dest_idx_i;

  logic                    eu_valid_o;
  logic                    eu_ready_i;
  logic [EU_CTL_LEN-1:0]   eu_ctl_o;
  logic [XLEN-1:0]         eu_rs1_o;
  logic [XLEN-1:0]         eu_rs2_o;
  logic [IDX_LEN-1:0]      eu_entry_idx_o;

  logic                    eu_valid_i;
  logic                    eu_ready_o;
  logic [IDX_LEN-1:0]      eu_entry_idx_i;
  logic [XLEN-1:0]         eu_result_i;
  logic                    eu_except_raised_i;
  logic [EXCEPT_LEN-1:0]   eu_except_code_i;

  logic                    cdb_valid_i;
  logic [ROB_IDX_LEN-1:0]  cdb_idx_i;
  logic [XLEN-1:0]         cdb_value_i;

  logic                    cdb_valid_o;
  logic                    cdb_ready_i;
  logic [ROB_IDX_LEN-1:0]  cdb_idx_o;
  logic [XLEN-1:0]         cdb_value_o;
  logic                    cdb_except_raised_o;
  logic [EXCEPT_LEN-1:0]   cdb_except_code_o;

  // Surrounding pipeline: issue stage, EU and CDB arbiter.
  modport master (
    output flush_i,
    output issue_valid_i, issue_eu_ctl_i,
    output issue_rs1_ready_i, issue_rs1_idx_i, issue_rs1_value_i,
    output issue_rs2_ready_i, issue_rs2_idx_i, issue_rs2_value_i,
    output issue_dest_idx_i,
    input  issue_ready_o,
    input  eu_valid_o, eu_ctl_o, eu_rs1_o, eu_rs2_o, eu_entry_idx_o,
    output eu_ready_i,
    output eu_valid_i, eu_entry_idx_i, eu_result_i, eu_except_raised_i, eu_except_code_i,
    input  eu_ready_o,
    output cdb_valid_i, cdb_idx_i, cdb_value_i,
    input  cdb_valid_o, cdb_idx_o, cdb_value_o, cdb_except_raised_o, cdb_except_code_o,
    output cdb_ready_i
  );

  // Reservation station itself.
  modport slave (
    input  flush_i,
    input  issue_valid_i, issue_eu_ctl_i,
    input  issue_rs1_ready_i, issue_rs1_idx_i, issue_rs1_value_i,
    input  issue_rs2_ready_i, issue_rs2_idx_i, issue_rs2_value_i,
    input  issue_dest_idx_i,
    output issue_ready_o,
    output eu_valid_o, eu_ctl_o, eu_rs1_o, eu_rs2_o, eu_entry_idx_o,
    input  eu_ready_i,
    input  eu_valid_i, eu_entry_idx_i, eu_result_i, eu_except_raised_i, eu_except_code_i,
    output eu_ready_o,
    input  cdb_valid_i, cdb_idx_i, cdb_value_i,
    output cdb_valid_o, cdb_idx_o, cdb_value_o, cdb_except_raised_o, cdb_except_code_o,
    input  cdb_ready_i
  );

endinterface

// File: rtl/simd_rs_prio_enc.sv
// Lowest-index-first priority encoder: request vector -> any + winning index.
module prio_enc #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/simd_rs.sv
// SIMD reservation station: holds issued ops until operands arrive, dispatches
// them to the EU, collects results and broadcasts them on the CDB.
module simd_rs
  import simd_rs_pkg::*;
(
  input logic      clk_i,
  input logic      rst_n_i,
  simd_rs_if.slave rs
);

  simd_rs_entry_t entries_q [RS_DEPTH];
  simd_rs_entry_t entries_d [RS_DEPTH];
  simd_rs_entry_t new_entry;

  logic [RS_DEPTH-1:0] empty_vec;
  logic [RS_DEPTH-1:0] ready_vec;
  logic [RS_DEPTH-1:0] completed_vec;

  logic               alloc_valid, disp_valid, wb_valid;
  logic [IDX_LEN-1:0] alloc_idx, disp_idx, wb_idx;
  logic               rs1_hit, rs2_hit;
  logic               result_ok;

  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_state_vec
    assign empty_vec[gi]     = (entries_q[gi].state == RS_EMPTY);
    assign ready_vec[gi]     = (entries_q[gi].state == RS_READY);
    assign completed_vec[gi] = (entries_q[gi].state == RS_COMPLETED);
  end

  prio_enc #(.N(RS_DEPTH), .W(IDX_LEN)) u_alloc_enc (
    .req_i(empty_vec), .valid_o(alloc_valid), .idx_o(alloc_idx)
  );
  prio_enc #(.N(RS_DEPTH), .W(IDX_LEN)) u_disp_enc (
    .req_i(ready_vec), .valid_o(disp_valid), .idx_o(disp_idx)
  );
  prio_enc #(.N(RS_DEPTH), .W(IDX_LEN)) u_wb_enc (
    .req_i(completed_vec), .valid_o(wb_valid), .idx_o(wb_idx)
  );

  // Outputs depend on registered state only; data is zeroed when not valid.
  assign rs.issue_ready_o       = alloc_valid;
  assign rs.eu_valid_o          = disp_valid;
  assign rs.eu_ctl_o            = disp_valid ? entries_q[disp_idx].ctl : '0;
  assign rs.eu_rs1_o            = disp_valid ? entries_q[disp_idx].rs1_value : '0;
  assign rs.eu_rs2_o            = disp_valid ? entries_q[disp_idx].rs2_value : '0;
  assign rs.eu_entry_idx_o      = disp_valid ? disp_idx : '0;
  assign rs.eu_ready_o          = 1'b1;
  assign rs.cdb_valid_o         = wb_valid;
  assign rs.cdb_idx_o           = wb_valid ? entries_q[wb_idx].dest_idx : '0;
  assign rs.cdb_value_o         = wb_valid ? entries_q[wb_idx].result : '0;
  assign rs.cdb_except_raised_o = wb_valid ? entries_q[wb_idx].except_raised : 1'b0;
  assign rs.cdb_except_code_o   = wb_valid ? entries_q[wb_idx].except_code : '0;

  assign result_ok = (entries_q[rs.eu_entry_idx_i].state == RS_EXECUTING);

  // Build the entry being issued, capturing an operand broadcast this very cycle.
  always_comb begin
    new_entry          = '0;
    rs1_hit            = cdb_hit(rs.issue_rs1_ready_i, rs.issue_rs1_idx_i,
                                 rs.cdb_valid_i, rs.cdb_idx_i);
    rs2_hit            = cdb_hit(rs.issue_rs2_ready_i, rs.issue_rs2_idx_i,
                                 rs.cdb_valid_i, rs.cdb_idx_i);
    new_entry.ctl      = rs.issue_eu_ctl_i;
    new_entry.dest_idx = rs.issue_dest_idx_i;
    new_entry.rs1_idx  = rs.issue_rs1_idx_i;
    new_entry.rs2_idx  = rs.issue_rs2_idx_i;
    new_entry.rs1_ready = rs.issue_rs1_ready_i | rs1_hit;
    new_entry.rs2_ready = rs.issue_rs2_ready_i | rs2_hit;
    new_entry.rs1_value = rs.issue_rs1_ready_i ? rs.issue_rs1_value_i :
                          (rs1_hit ? rs.cdb_value_i : '0);
    new_entry.rs2_value = rs.issue_rs2_ready_i ? rs.issue_rs2_value_i :
                          (rs2_hit ? rs.cdb_value_i : '0);
    new_entry.state     = (new_entry.rs1_ready && new_entry.rs2_ready) ? RS_READY : RS_PENDING;
  end

  // Per-cycle entry update: snoop, dispatch, result, writeback, allocate, flush.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) entries_d[i] = entries_q[i];

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (entries_q[i].state == RS_PENDING) begin
        if (cdb_hit(entries_q[i].rs1_ready, entries_q[i].rs1_idx, rs.cdb_valid_i, rs.cdb_idx_i)) begin
          entries_d[i].rs1_ready = 1'b1;
          entries_d[i].rs1_value = rs.cdb_value_i;
        end
        if (cdb_hit(entries_q[i].rs2_ready, entries_q[i].rs2_idx, rs.cdb_valid_i, rs.cdb_idx_i)) begin
          entries_d[i].rs2_ready = 1'b1;
          entries_d[i].rs2_value = rs.cdb_value_i;
        end
        if (entries_d[i].rs1_ready && entries_d[i].rs2_ready) entries_d[i].state = RS_READY;
      end
    end

    if (disp_valid && rs.eu_ready_i) entries_d[disp_idx].state = RS_EXECUTING;

    // Results for entries that are not executing are dropped.
    if (rs.eu_valid_i && result_ok) begin
      entries_d[rs.eu_entry_idx_i].state         = RS_COMPLETED;
      entries_d[rs.eu_entry_idx_i].result        = rs.eu_result_i;
      entries_d[rs.eu_entry_idx_i].except_raised = rs.eu_except_raised_i;
      entries_d[rs.eu_entry_idx_i].except_code   = rs.eu_except_code_i;
    end

    if (wb_valid && rs.cdb_ready_i) entries_d[wb_idx].state = RS_EMPTY;

    // The allocated slot was EMPTY in registered state, so it never collides
    // with the slot freed by writeback in the same cycle.
    if (rs.issue_valid_i && alloc_valid) entries_d[alloc_idx] = new_entry;

    if (rs.flush_i) begin
      for (int i = 0; i < RS_DEPTH; i++) entries_d[i] = '0;
    end
  end

  // Entry storage; reset empties and zeroes every slot immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RS_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

  a_result_for_executing: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) rs.eu_valid_i |-> result_ok
  );

endmodule
